// File: rtl/barrel_shift_arbiter.sv
// ============================================================================
// Module   : barrel_shift_arbiter
// Brief    : Round-robin sharing of one rotate-left barrel shifter with a
//            registered, ID-tagged valid/ready response channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module barrel_shifter #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [DATA_WIDTH-1:0]  result
);

  localparam int c_stages = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [c_stages-1:0]   w_amt;
  logic [DATA_WIDTH-1:0] w_stage [c_stages+1];

  // Power-of-two widths wrap naturally; other widths need an explicit modulo.
  if ((2 ** c_stages) == DATA_WIDTH) begin : g_pow2
    assign w_amt = shift[c_stages-1:0];
  end else begin : g_mod
    localparam logic [SHIFT_WIDTH-1:0] c_dw = SHIFT_WIDTH'(DATA_WIDTH);
    logic [SHIFT_WIDTH-1:0] w_mod;
    assign w_mod = shift % c_dw;
    assign w_amt = w_mod[c_stages-1:0];
  end

  assign w_stage[0] = data;

  for (genvar k = 0; k < c_stages; k++) begin : g_stage
    localparam int c_s = 1 << k;
    assign w_stage[k+1] = w_amt[k]
      ? {w_stage[k][DATA_WIDTH-1-c_s:0], w_stage[k][DATA_WIDTH-1 -: c_s]}
      : w_stage[k];
  end

  assign result = w_stage[c_stages];

endmodule

module barrel_shift_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int SHIFT_WIDTH = (2 ** $clog2(DATA_WIDTH) == DATA_WIDTH) ?
                              $clog2(DATA_WIDTH) : $clog2(DATA_WIDTH) + 1,
  parameter int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_in,
  input  logic [NUM_REQ*SHIFT_WIDTH-1:0] req_shift_in,
  output logic                           rsp_valid_out,
  input  logic                           rsp_ready_in,
  output logic [DATA_WIDTH-1:0]          rsp_data_out,
  output logic [ID_WIDTH-1:0]            rsp_id_out
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  localparam logic [ID_WIDTH:0]   c_num     = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] c_last_id = ID_WIDTH'(NUM_REQ - 1);

  state_t                  r_state;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic [ID_WIDTH-1:0]     r_rsp_id;
  logic [ID_WIDTH-1:0]     r_rr_ptr;

  logic                    w_found;
  logic [ID_WIDTH-1:0]     w_winner;
  logic [ID_WIDTH:0]       w_idx;
  logic [NUM_REQ-1:0]      w_win_oh;
  logic                    w_slot_free;
  logic                    w_grant;
  logic [ID_WIDTH-1:0]     w_next_ptr;
  logic [DATA_WIDTH-1:0]   w_op_data;
  logic [SHIFT_WIDTH-1:0]  w_op_shift;
  logic [DATA_WIDTH-1:0]   w_rot;

  // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(i);
      if (w_idx >= c_num) begin
        w_idx = w_idx - c_num;
      end
      if (!w_found && req_valid_in[w_idx[ID_WIDTH-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_oh[i] = w_found && (w_winner == ID_WIDTH'(i));
    end
  end

  assign w_slot_free   = !r_rsp_valid || rsp_ready_in;
  assign w_grant       = w_found && w_slot_free && rst_n;
  assign req_ready_out = w_grant ? w_win_oh : '0;
  assign w_next_ptr    = (w_winner == c_last_id) ? '0 : w_winner + ID_WIDTH'(1);

  always_comb begin
    w_op_data  = '0;
    w_op_shift = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_op_data  = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        w_op_shift = req_shift_in[i*SHIFT_WIDTH +: SHIFT_WIDTH];
      end
    end
  end

  barrel_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shifter (
    .data   (w_op_data),
    .shift  (w_op_shift),
    .result (w_rot)
  );

  // A stalled response blocks grants, so FULL & !rsp_ready never loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_grant) begin
        r_rsp_data <= w_rot;
        r_rsp_id   <= w_winner;
        r_rr_ptr   <= w_next_ptr;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state     <= ST_FULL;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (rsp_ready_in && !w_grant) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_out = r_rsp_valid;
  assign rsp_data_out  = r_rsp_data;
  assign rsp_id_out    = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_barrel_shift_arbiter.sv
// ============================================================================
// Module   : tb_barrel_shift_arbiter
// Brief    : Directed and randomized self-checking bench for barrel_shift_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_barrel_shift_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int SW = 3;
  localparam int IW = 2;

  logic           clk;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] req_data;
  logic [NR*SW-1:0] req_shift;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic [IW-1:0]  rsp_id;

  int n_checks = 0;
  int n_errors = 0;

  barrel_shift_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .req_data_in   (req_data),
    .req_shift_in  (req_shift),
    .rsp_valid_out (rsp_valid),
    .rsp_ready_in  (rsp_ready),
    .rsp_data_out  (rsp_data),
    .rsp_id_out    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] s);
    req_data[i*DW +: DW]  = d;
    req_shift[i*SW +: SW] = s;
  endtask

  task automatic check_rsp(input string tag, input logic [7:0] d, input logic [1:0] id);
    check_value({tag, "_valid"}, rsp_valid, 1);
    check_value({tag, "_data"}, rsp_data, d);
    check_value({tag, "_id"}, rsp_id, id);
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] d, input logic [2:0] s);
    logic [7:0] r;
    r = d;
    for (int k = 0; k < int'(s); k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  logic [7:0] t3_data [6] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h02, 8'h04};
  logic [1:0] t3_id   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0] t5_id   [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
  logic [7:0] t5_data [4] = '{8'h04, 8'h10, 8'h04, 8'h10};

  initial begin
    logic [9:0] exp_q[$];
    logic [9:0] head;
    logic [NR-1:0] acc;
    int created;
    int received;
    int cyc;

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    req_shift = '0;
    rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    #1;
    check_value("rst_ready", req_ready, 4'b0000);
    check_value("rst_valid", rsp_valid, 0);
    check_value("rst_data", rsp_data, 0);
    check_value("rst_id", rsp_id, 0);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    tick();

    // Single rotate, requester 0
    set_req(0, 8'h81, 3'd1);
    req_valid = 4'b0001;
    #1;
    check_value("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    check_rsp("t1", 8'h03, 2'd0);
    tick();
    check_value("t1_drain", rsp_valid, 0);

    // Requester 2, then shift of zero
    set_req(2, 8'hB4, 3'd3);
    req_valid = 4'b0100;
    #1;
    check_value("t2_ready", req_ready, 4'b0100);
    tick();
    check_rsp("t2_rot3", 8'hA5, 2'd2);
    set_req(2, 8'hB4, 3'd0);
    tick();
    req_valid = 4'b0000;
    check_rsp("t2_rot0", 8'hB4, 2'd2);
    tick();

    // All requesters from reset: round-robin order back to back
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 8'h01 << i, 3'd1);
    req_valid = 4'b1111;
    #1;
    check_value("t3_first_ready", req_ready, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_rsp($sformatf("t3_g%0d", k), t3_data[k], t3_id[k]);
    end

    // Backpressure: held response stays stable, no grants
    rsp_ready = 1'b0;
    #1;
    check_value("t4_ready_blocked", req_ready, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_rsp($sformatf("t4_hold%0d", k), 8'h04, 2'd1);
      check_value("t4_ready_hold", req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    #1;
    check_value("t4_release_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    check_rsp("t4_next", 8'h08, 2'd2);
    tick();
    check_value("t4_idle", rsp_valid, 0);

    // Lone requester 3 granted every cycle, then 1 and 3 alternate
    set_req(3, 8'h08, 3'd1);
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_value("t5_solo_ready", req_ready, 4'b1000);
      tick();
      check_rsp("t5_solo", 8'h10, 2'd3);
    end
    set_req(1, 8'h02, 3'd1);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_rsp($sformatf("t5_pair%0d", k), t5_data[k], t5_id[k]);
    end

    // Asynchronous reset with a response pending
    req_valid = 4'b1111;
    tick();
    check_rsp("t6_pre", 8'h02, 2'd0);
    rst_n = 1'b0;
    #1;
    check_value("t6_async_valid", rsp_valid, 0);
    check_value("t6_async_ready", req_ready, 4'b0000);
    check_value("t6_async_data", rsp_data, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check_value("t6_ptr_ready", req_ready, 4'b0001);
    tick();
    check_rsp("t6_first", 8'h02, 2'd0);
    req_valid = 4'b0000;
    tick();

    // Random traffic against an in-order scoreboard
    created  = 0;
    received = 0;
    cyc      = 0;
    while ((created < 20 || exp_q.size() > 0 || req_valid != 0) && cyc < 400) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && created < 20 && $urandom_range(0, 1) == 1) begin
          set_req(i, 8'($urandom), 3'($urandom));
          req_valid[i] = 1'b1;
          created++;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (rsp_valid && rsp_ready) begin
        check_value("t7_rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          check_value("t7_id", rsp_id, head[9:8]);
          check_value("t7_data", rsp_data, head[7:0]);
          received++;
        end
      end
      check_value("t7_onehot", $onehot0(req_ready), 1);
      acc = req_valid & req_ready;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) exp_q.push_back({2'(i), rotl8(req_data[i*DW +: DW], req_shift[i*SW +: SW])});
      end
      tick();
      req_valid = req_valid & ~acc;
      cyc++;
    end
    check_value("t7_timeout", cyc < 400, 1);
    check_value("t7_received", received, 20);
    check_value("t7_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
